// File: rtl/controle_registrador_pkg.sv
// rtl/controle_registrador_pkg.sv - register mode codes, command codes and sequencer states
package controle_registrador_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_ROT   = 2'b11;

  typedef enum logic [1:0] {
    OP_LOAD       = 2'b00,
    OP_SHIFT      = 2'b01,
    OP_LOAD_SHIFT = 2'b10,
    OP_ROTATE     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_has_load(op_e op);
    return (op == OP_LOAD) || (op == OP_LOAD_SHIFT);
  endfunction

endpackage

// File: rtl/controle_registrador_if.sv
// rtl/controle_registrador_if.sv - command/status bus between the system FSM and the sequencer
interface controle_registrador_if #(
  parameter int WIDTH = 14,
  parameter int CNT_W = 4
);
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] word_in;
  logic             fill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] captured;

  modport master (output start, op, count, word_in, fill, input busy, done, captured);
  modport slave  (input start, op, count, word_in, fill, output busy, done, captured);
endinterface

// File: rtl/controle_registrador_contador_ciclos.sv
// rtl/controle_registrador_contador_ciclos.sv - loadable down-counter; term flags the last RUN cycle
module contador_ciclos #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         term
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == W'(1));

endmodule

// File: rtl/controle_registrador.sv
// rtl/controle_registrador.sv - sequences load/shift/rotate commands onto the 14-bit mode register
module controle_registrador
  import controle_registrador_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  controle_registrador_if.slave  bus,
  input  logic                   reg_last,
  output logic                   ch0,
  output logic                   ch1,
  output logic                   d,
  output logic [WIDTH-1:0]       bits
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             fill_q, fill_d;
  logic [1:0]       ch_q, ch_d;
  logic             d_q, d_d;
  logic [WIDTH-1:0] bits_q, bits_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] captured_q, captured_d;

  logic [CNT_W-1:0] count_sat;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_term;

  assign count_sat = (bus.count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.count;
  assign cnt_dec   = (state_q == ST_RUN);

  contador_ciclos #(.W(CNT_W)) u_contador (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (count_sat),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .term     (cnt_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_LOAD;
      word_q     <= '0;
      fill_q     <= 1'b0;
      ch_q       <= MODE_HOLD;
      d_q        <= 1'b0;
      bits_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      captured_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      word_q     <= word_d;
      fill_q     <= fill_d;
      ch_q       <= ch_d;
      d_q        <= d_d;
      bits_q     <= bits_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      captured_q <= captured_d;
    end
  end

  // Next state plus command latching; captured samples reg_last before the shift edge acts.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    word_d     = word_q;
    fill_d     = fill_q;
    captured_d = captured_q;
    cnt_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d       = op_e'(bus.op);
          word_d     = bus.word_in;
          fill_d     = bus.fill;
          captured_d = '0;
          cnt_load   = 1'b1;
          if (op_has_load(op_e'(bus.op))) begin
            state_d = ST_LOAD;
          end else if (count_sat != '0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        state_d = ((op_q == OP_LOAD_SHIFT) && (cnt_val != '0)) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        captured_d = {captured_q[WIDTH-2:0], reg_last};
        if (cnt_term) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    ch_d   = MODE_HOLD;
    d_d    = d_q;
    bits_d = bits_q;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    case (state_d)
      ST_LOAD: begin
        ch_d   = MODE_LOAD;
        bits_d = word_d;
      end
      ST_RUN: begin
        if (op_d == OP_ROTATE) begin
          ch_d = MODE_ROT;
        end else begin
          ch_d = MODE_SHIFT;
          d_d  = fill_d;
        end
      end
      default: begin
        ch_d = MODE_HOLD;
      end
    endcase
  end

  assign ch0          = ch_q[0];
  assign ch1          = ch_q[1];
  assign d            = d_q;
  assign bits         = bits_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.captured = captured_q;

endmodule

// File: tb/tb_controle_registrador.sv
// tb/tb_controle_registrador.sv - directed vectors for the register sequencer with a register model
`timescale 1ns/1ps
module tb_controle_registrador;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_last;
  logic        ch0, ch1, d;
  logic [13:0] bits;
  logic [13:0] r = 14'h0;

  int pass_cnt = 0;
  int total_cnt = 0;

  controle_registrador_if #(.WIDTH(14), .CNT_W(4)) bus ();

  controle_registrador #(.WIDTH(14), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .reg_last (reg_last),
    .ch0      (ch0),
    .ch1      (ch1),
    .d        (d),
    .bits     (bits)
  );

  always #5 clk = ~clk;

  // Behavioural model of the mode-controlled shift register being sequenced.
  always @(posedge clk) begin
    case ({ch1, ch0})
      2'b01:   r <= {r[12:0], d};
      2'b10:   r <= bits;
      2'b11:   r <= {r[12:0], r[13]};
      default: r <= r;
    endcase
  end
  assign reg_last = r[13];

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  cnt;
    logic [13:0] word;
    logic        fl;
    int          lat;
    int          nrun;
    int          nload;
    logic [13:0] reg_exp;
    logic [13:0] capt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Issues one command and watches 20 cycles; inject_at>0 pulses a LOAD start mid-command.
  task automatic run_cmd(input logic [1:0] opv, input logic [3:0] cnt, input logic [13:0] wd,
                         input logic fl, input int inject_at,
                         output int lat, output int nrun, output int nload, output int ndone);
    logic [1:0] run_mode;
    run_mode = (opv == 2'b11) ? 2'b11 : 2'b01;
    lat = 0; nrun = 0; nload = 0; ndone = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = opv; bus.count = cnt; bus.word_in = wd; bus.fill = fl;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ({ch1, ch0} == 2'b10) nload++;
      if ({ch1, ch0} == run_mode && (opv == 2'b11 || d == fl)) nrun++;
      if (bus.done) begin
        ndone++;
        if (lat == 0) lat = k;
      end
      if (k == inject_at) begin
        bus.start = 1'b1; bus.op = 2'b00; bus.word_in = 14'h3333;
      end else begin
        bus.start = 1'b0; bus.op = ~opv; bus.count = ~cnt; bus.word_in = ~wd; bus.fill = ~fl;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int lat, nrun, nload, ndone;
    bit saw_done;

    vecs[0] = '{2'b00, 4'd0,  14'h2A5B, 1'b0, 2,  0,  1, 14'h2A5B, 14'h0000};
    vecs[1] = '{2'b10, 4'd3,  14'h3FFF, 1'b0, 5,  3,  1, 14'h3FF8, 14'h0007};
    vecs[2] = '{2'b00, 4'd0,  14'h1234, 1'b0, 2,  0,  1, 14'h1234, 14'h0000};
    vecs[3] = '{2'b11, 4'd14, 14'h0000, 1'b0, 15, 14, 0, 14'h1234, 14'h1234};
    vecs[4] = '{2'b11, 4'd15, 14'h0000, 1'b0, 15, 14, 0, 14'h1234, 14'h1234};
    vecs[5] = '{2'b01, 4'd0,  14'h0000, 1'b1, 1,  0,  0, 14'h1234, 14'h0000};
    vecs[6] = '{2'b01, 4'd4,  14'h0000, 1'b1, 5,  4,  0, 14'h234F, 14'h0004};
    vecs[7] = '{2'b10, 4'd2,  14'h0001, 1'b1, 4,  2,  1, 14'h0007, 14'h0000};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.count = 4'd0; bus.word_in = 14'h0; bus.fill = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ch",       {ch1, ch0}, 2'b00);
    check("reset_d",        d, 1'b0);
    check("reset_bits",     bits, 14'h0);
    check("reset_busy",     bus.busy, 1'b0);
    check("reset_done",     bus.done, 1'b0);
    check("reset_captured", bus.captured, 14'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy", bus.busy, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].op, vecs[i].cnt, vecs[i].word, vecs[i].fl, 0, lat, nrun, nload, ndone);
      check($sformatf("v%0d_latency", i),  lat,   vecs[i].lat);
      check($sformatf("v%0d_run_cyc", i),  nrun,  vecs[i].nrun);
      check($sformatf("v%0d_load_cyc", i), nload, vecs[i].nload);
      check($sformatf("v%0d_done_cnt", i), ndone, 1);
      check($sformatf("v%0d_register", i), r, vecs[i].reg_exp);
      check($sformatf("v%0d_captured", i), bus.captured, vecs[i].capt);
      check($sformatf("v%0d_busy_end", i), bus.busy, 1'b0);
    end

    // start pulsed during a 10-cycle RUN must be dropped
    run_cmd(2'b01, 4'd10, 14'h0000, 1'b1, 4, lat, nrun, nload, ndone);
    check("inj_latency",  lat,   11);
    check("inj_run_cyc",  nrun,  10);
    check("inj_load_cyc", nload, 0);
    check("inj_done_cnt", ndone, 1);
    check("inj_register", r, 14'h1FFF);

    // start in the DONE cycle must be dropped
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.count = 4'd0; bus.fill = 1'b0;
    @(negedge clk);
    bus.op = 2'b00; bus.word_in = 14'h0F0F;
    check("cnt0_done_c1", bus.done, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    check("donestart_busy", bus.busy, 1'b0);
    check("donestart_ch",   {ch1, ch0}, 2'b00);
    repeat (2) @(negedge clk);
    check("donestart_reg",  r, 14'h1FFF);

    // reset asserted in RUN cycle 4 of 8
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.count = 4'd8; bus.fill = 1'b0;
    saw_done = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) saw_done = 1'b1;
    end
    check("rst_mid_ch_before", {ch1, ch0}, 2'b01);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ch",   {ch1, ch0}, 2'b00);
    check("rst_mid_busy", bus.busy, 1'b0);
    repeat (2) @(negedge clk);
    if (bus.done) saw_done = 1'b1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("rst_mid_no_done", saw_done, 1'b0);
    check("rst_mid_register", r, 14'h3FF8);
    check("rst_mid_idle", bus.busy, 1'b0);

    run_cmd(2'b00, 4'd0, 14'h0ABC, 1'b0, 0, lat, nrun, nload, ndone);
    check("post_rst_latency",  lat, 2);
    check("post_rst_done_cnt", ndone, 1);
    check("post_rst_register", r, 14'h0ABC);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
